// File: rtl/binary_decoder_pkg.sv
// Shared constants, button indices and the repeat FSM state type for the
// binary value front end.
package binary_decoder_pkg;

  localparam int NUM_BUTTONS = 4;

  localparam int BTN_UP    = 0;
  localparam int BTN_DOWN  = 1;
  localparam int BTN_LOAD  = 2;
  localparam int BTN_CLEAR = 3;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 1_000_000;
  localparam int DEFAULT_REPEAT_DELAY    = 50_000_000;
  localparam int DEFAULT_REPEAT_PERIOD   = 10_000_000;

  typedef enum logic [1:0] {
    REP_IDLE   = 2'd0,
    REP_HELD   = 2'd1,
    REP_REPEAT = 2'd2
  } repeatState_t;

  // Modular 8-bit step; simultaneous up and down cancel out.
  function automatic logic [7:0] stepValue(input logic [7:0] current,
                                           input logic       stepUp,
                                           input logic       stepDown);
    logic [7:0] result;
    result = current;
    if (stepUp && !stepDown) begin
      result = current + 8'd1;
    end else if (stepDown && !stepUp) begin
      result = current - 8'd1;
    end
    return result;
  endfunction

endpackage

// File: rtl/button_debouncer.sv
// Two-flop synchronizer followed by a debounce counter; emits the accepted
// level and a single-cycle pulse on each accepted press.
module button_debouncer
  import binary_decoder_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             syncStage1;
  logic             syncStage2;
  logic [CNT_W-1:0] stableCount;

  // Synchronize the raw pin, then flip the accepted level only after the
  // synchronized level has disagreed with it for a full run of cycles.
  always_ff @(posedge clock) begin
    if (reset) begin
      syncStage1  <= 1'b0;
      syncStage2  <= 1'b0;
      stableCount <= '0;
      level       <= 1'b0;
      press       <= 1'b0;
    end else begin
      syncStage1 <= raw;
      syncStage2 <= syncStage1;
      press      <= 1'b0;
      if (syncStage2 != level) begin
        if (stableCount == CNT_LAST) begin
          level       <= syncStage2;
          press       <= syncStage2;
          stableCount <= '0;
        end else begin
          stableCount <= stableCount + 1'b1;
        end
      end else begin
        stableCount <= '0;
      end
    end
  end

endmodule

// File: rtl/binary_value_encoder.sv
// Button front end: debounces four push-buttons, runs auto-repeat for
// up/down and maintains the registered 8-bit value for the display decoder.
module binary_value_encoder
  import binary_decoder_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEFAULT_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEFAULT_REPEAT_PERIOD
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] switches,
  input  logic       btnUp,
  input  logic       btnDown,
  input  logic       btnLoad,
  input  logic       btnClear,
  output logic [7:0] value,
  output logic       valueChanged,
  output logic [3:0] buttonsHeld
);

  localparam int REPEAT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int REP_W      = $clog2(REPEAT_MAX + 1);
  localparam logic [REP_W-1:0] DELAY_LAST  = REP_W'(REPEAT_DELAY - 1);
  localparam logic [REP_W-1:0] PERIOD_LAST = REP_W'(REPEAT_PERIOD - 1);

  logic [NUM_BUTTONS-1:0] rawButtons;
  logic [NUM_BUTTONS-1:0] heldLevels;
  logic [NUM_BUTTONS-1:0] pressPulse;

  repeatState_t     repState     [2];
  repeatState_t     repStateNext [2];
  logic [REP_W-1:0] repCount     [2];
  logic [REP_W-1:0] repCountNext [2];
  logic [1:0]       stepReq;
  logic [7:0]       valueNext;

  assign rawButtons  = {btnClear, btnLoad, btnDown, btnUp};
  assign buttonsHeld = heldLevels;

  for (genvar b = 0; b < NUM_BUTTONS; b++) begin : gDebounce
    button_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) uDebouncer (
      .clock(clock),
      .reset(reset),
      .raw  (rawButtons[b]),
      .level(heldLevels[b]),
      .press(pressPulse[b])
    );
  end

  // State and counter registers for the up (0) and down (1) repeat FSMs.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        repState[i] <= REP_IDLE;
        repCount[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        repState[i] <= repStateNext[i];
        repCount[i] <= repCountNext[i];
      end
    end
  end

  // Repeat FSM: step on press, again after the initial delay, then once per
  // period until the debounced button is released.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      repStateNext[i] = repState[i];
      repCountNext[i] = repCount[i];
      stepReq[i]      = 1'b0;
      case (repState[i])
        REP_IDLE: begin
          repCountNext[i] = '0;
          if (pressPulse[i]) begin
            repStateNext[i] = REP_HELD;
            stepReq[i]      = 1'b1;
          end
        end
        REP_HELD: begin
          if (!heldLevels[i]) begin
            repStateNext[i] = REP_IDLE;
            repCountNext[i] = '0;
          end else if (repCount[i] == DELAY_LAST) begin
            repStateNext[i] = REP_REPEAT;
            repCountNext[i] = '0;
            stepReq[i]      = 1'b1;
          end else begin
            repCountNext[i] = repCount[i] + 1'b1;
          end
        end
        REP_REPEAT: begin
          if (!heldLevels[i]) begin
            repStateNext[i] = REP_IDLE;
            repCountNext[i] = '0;
          end else if (repCount[i] == PERIOD_LAST) begin
            repCountNext[i] = '0;
            stepReq[i]      = 1'b1;
          end else begin
            repCountNext[i] = repCount[i] + 1'b1;
          end
        end
        default: begin
          repStateNext[i] = REP_IDLE;
          repCountNext[i] = '0;
        end
      endcase
    end
  end

  // Pick the next value with clear over load over stepping.
  always_comb begin
    valueNext = value;
    if (pressPulse[BTN_CLEAR]) begin
      valueNext = 8'd0;
    end else if (pressPulse[BTN_LOAD]) begin
      valueNext = switches;
    end else begin
      valueNext = stepValue(value, stepReq[BTN_UP], stepReq[BTN_DOWN]);
    end
  end

  // Value register; the change flag is high only when the stored value moves.
  always_ff @(posedge clock) begin
    if (reset) begin
      value        <= 8'd0;
      valueChanged <= 1'b0;
    end else begin
      value        <= valueNext;
      valueChanged <= (valueNext != value);
    end
  end

endmodule

// File: tb/tb_binary_value_encoder.sv
// Directed bench for binary_value_encoder with short debounce/repeat timing.
module tb_binary_value_encoder;

  localparam logic [3:0] M_UP    = 4'b0001;
  localparam logic [3:0] M_DOWN  = 4'b0010;
  localparam logic [3:0] M_LOAD  = 4'b0100;
  localparam logic [3:0] M_CLEAR = 4'b1000;

  logic       clock;
  logic       reset;
  logic [7:0] switches;
  logic       btnUp;
  logic       btnDown;
  logic       btnLoad;
  logic       btnClear;
  logic [7:0] value;
  logic       valueChanged;
  logic [3:0] buttonsHeld;

  int passCount  = 0;
  int checkCount = 0;

  binary_value_encoder #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (10),
    .REPEAT_PERIOD  (3)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .switches    (switches),
    .btnUp       (btnUp),
    .btnDown     (btnDown),
    .btnLoad     (btnLoad),
    .btnClear    (btnClear),
    .value       (value),
    .valueChanged(valueChanged),
    .buttonsHeld (buttonsHeld)
  );

  // Free-running clock, 10 time units per cycle.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic applyStimulus(input logic [3:0] mask);
    btnUp    = mask[0];
    btnDown  = mask[1];
    btnLoad  = mask[2];
    btnClear = mask[3];
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
  endtask

  // Press from a negedge: after 7 negedges the step edge (N+6) has passed.
  task automatic press(input logic [3:0] mask);
    applyStimulus(mask);
    cycles(7);
  endtask

  task automatic releaseAll();
    applyStimulus(4'b0000);
    cycles(8);
  endtask

  initial begin
    reset    = 1'b1;
    switches = 8'h00;
    applyStimulus(4'b0000);
    cycles(3);
    checkOutput("resetValue", 32'(value), 32'h00);
    checkOutput("resetChanged", 32'(valueChanged), 32'h0);
    checkOutput("resetHeld", 32'(buttonsHeld), 32'h0);
    reset = 1'b0;
    cycles(2);

    // Clean up press: nothing before edge N+6, single step at N+6.
    applyStimulus(M_UP);
    cycles(6);
    checkOutput("upNoEarlyStep", 32'(value), 32'h00);
    checkOutput("upHeldLed", 32'(buttonsHeld), 32'h1);
    cycles(1);
    checkOutput("upValue", 32'(value), 32'h01);
    checkOutput("upPulse", 32'(valueChanged), 32'h1);
    cycles(1);
    checkOutput("upPulseOneCycle", 32'(valueChanged), 32'h0);
    applyStimulus(4'b0000);
    cycles(10);
    checkOutput("upReleaseNoRepeat", 32'(value), 32'h01);
    checkOutput("upReleaseLed", 32'(buttonsHeld), 32'h0);

    // Bouncing up: short glitches ignored, one step timed from last bounce.
    applyStimulus(M_UP);
    cycles(1);
    applyStimulus(4'b0000);
    cycles(1);
    applyStimulus(M_UP);
    cycles(2);
    applyStimulus(4'b0000);
    cycles(1);
    checkOutput("bounceNoEvent", 32'(value), 32'h01);
    applyStimulus(M_UP);
    cycles(6);
    checkOutput("bounceNoEarlyStep", 32'(value), 32'h01);
    cycles(1);
    checkOutput("bounceValue", 32'(value), 32'h02);
    checkOutput("bouncePulse", 32'(valueChanged), 32'h1);
    releaseAll();

    // Wrap in both directions.
    switches = 8'hFF;
    press(M_LOAD);
    checkOutput("loadFF", 32'(value), 32'hFF);
    releaseAll();
    press(M_UP);
    checkOutput("wrapUpValue", 32'(value), 32'h00);
    checkOutput("wrapUpPulse", 32'(valueChanged), 32'h1);
    releaseAll();
    press(M_DOWN);
    checkOutput("wrapDownValue", 32'(value), 32'hFF);
    checkOutput("wrapDownPulse", 32'(valueChanged), 32'h1);
    releaseAll();

    // Load, identical reload, clear-over-load, clear at zero.
    switches = 8'hA5;
    press(M_LOAD);
    checkOutput("loadA5Value", 32'(value), 32'hA5);
    checkOutput("loadA5Pulse", 32'(valueChanged), 32'h1);
    releaseAll();
    press(M_LOAD);
    checkOutput("reloadA5Value", 32'(value), 32'hA5);
    checkOutput("reloadA5NoPulse", 32'(valueChanged), 32'h0);
    releaseAll();
    switches = 8'h3C;
    press(M_CLEAR | M_LOAD);
    checkOutput("clearBeatsLoad", 32'(value), 32'h00);
    checkOutput("clearBeatsLoadPulse", 32'(valueChanged), 32'h1);
    releaseAll();
    press(M_CLEAR);
    checkOutput("clearAtZeroNoPulse", 32'(valueChanged), 32'h0);
    releaseAll();

    // Auto-repeat: steps at E0+0,10,13,16,19,22,25; release ends it before +28.
    press(M_UP);
    checkOutput("repeatFirst", 32'(value), 32'h01);
    cycles(9);
    checkOutput("repeatNotEarly", 32'(value), 32'h01);
    cycles(1);
    checkOutput("repeatDelayStep", 32'(value), 32'h02);
    checkOutput("repeatDelayPulse", 32'(valueChanged), 32'h1);
    cycles(2);
    checkOutput("repeatPeriodGap", 32'(value), 32'h02);
    cycles(1);
    checkOutput("repeatPeriodStep", 32'(value), 32'h03);
    cycles(7);
    checkOutput("repeatAt20", 32'(value), 32'h05);
    applyStimulus(4'b0000);
    cycles(5);
    checkOutput("repeatLastStep", 32'(value), 32'h07);
    cycles(10);
    checkOutput("repeatStopped", 32'(value), 32'h07);

    // Coincident up and down presses cancel.
    press(M_UP | M_DOWN);
    checkOutput("cancelValue", 32'(value), 32'h07);
    checkOutput("cancelNoPulse", 32'(valueChanged), 32'h0);
    releaseAll();
    checkOutput("cancelAfterRelease", 32'(value), 32'h07);

    // Reset in the middle of a repeat, with up held through release of reset.
    press(M_UP);
    cycles(12);
    checkOutput("preResetValue", 32'(value), 32'h09);
    reset = 1'b1;
    cycles(2);
    checkOutput("midResetValue", 32'(value), 32'h00);
    checkOutput("midResetHeld", 32'(buttonsHeld), 32'h0);
    reset = 1'b0;
    cycles(2);
    checkOutput("postResetNoStep", 32'(value), 32'h00);
    checkOutput("postResetNoPulse", 32'(valueChanged), 32'h0);
    cycles(4);
    checkOutput("postResetDebouncing", 32'(value), 32'h00);
    cycles(1);
    checkOutput("postResetNewPress", 32'(value), 32'h01);
    checkOutput("postResetPulse", 32'(valueChanged), 32'h1);
    releaseAll();

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
